// File: rtl/usrt_pkg.sv
// Shared USRT definitions: parity mode encodings and the framer state enum,
// used by both the RX and TX framers.
package usrt_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;
  localparam logic [1:0] PAR_MARK = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_IDLE
  } usrt_state_e;

endpackage

// File: rtl/usrt_parity_acc.sv
// Running XOR over data and parity bits plus a captured copy of the parity bit;
// err is the mode-dependent verdict, meaningful once the parity bit is in.
module usrt_parity_acc
  import usrt_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       par_en,
  input  logic       din,
  input  logic [1:0] mode,
  output logic       err
);

  logic acc;
  logic par_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= 1'b0;
      par_bit <= 1'b0;
    end else if (clr) begin
      acc     <= 1'b0;
      par_bit <= 1'b0;
    end else begin
      if (en)     acc     <= acc ^ din;
      if (par_en) par_bit <= din;
    end
  end

  always_comb begin
    err = 1'b0;
    case (mode)
      PAR_EVEN: err = acc;
      PAR_ODD:  err = ~acc;
      PAR_MARK: err = ~par_bit;
      default:  err = 1'b0;
    endcase
  end

endmodule

// File: rtl/usrt_rx_framer.sv
// USRT receive framer: start/data/parity/stop delimiting on a bit strobe,
// parity and stop checking, per-frame status and a saturating error counter.
module usrt_rx_framer
  import usrt_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int STOP_BITS = 1,
  parameter int CNT_W     = 8
) (
  input  logic              i_Pclk,
  input  logic              i_Rst,
  input  logic              i_BitEn,
  input  logic              i_Rx,
  input  logic [1:0]        i_Parity,
  input  logic              i_ClrCnt,
  output logic [DATA_W-1:0] o_Data,
  output logic              o_Valid,
  output logic              o_ParityErr,
  output logic              o_FrameErr,
  output logic              o_Busy,
  output logic [CNT_W-1:0]  o_ErrCnt
);

  localparam int BCW = $clog2(DATA_W);

  usrt_state_e       state, state_nxt;
  logic [DATA_W-1:0] shreg;
  logic [BCW-1:0]    bit_cnt;
  logic              stop_cnt;
  logic [1:0]        mode;
  logic              ferr_acc;
  logic              perr;
  logic              data_last, stop_last;
  logic              start, acc_en, par_en, frame_done, frame_bad;

  assign data_last = (bit_cnt == BCW'(DATA_W - 1));
  assign stop_last = (stop_cnt == 1'(STOP_BITS - 1));
  // the final stop bit itself still counts toward the frame error
  assign frame_bad = perr | ferr_acc | ~i_Rx;

  always_ff @(posedge i_Pclk or posedge i_Rst) begin
    if (i_Rst) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (i_BitEn) begin
      case (state)
        ST_IDLE:      if (!i_Rx) state_nxt = ST_DATA;
        ST_DATA:      if (data_last) state_nxt = (mode == PAR_NONE) ? ST_STOP : ST_PARITY;
        ST_PARITY:    state_nxt = ST_STOP;
        ST_STOP:      if (stop_last) state_nxt = i_Rx ? ST_IDLE : ST_WAIT_IDLE;
        ST_WAIT_IDLE: if (i_Rx) state_nxt = ST_IDLE;
        default:      state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    o_Busy     = (state == ST_DATA) || (state == ST_PARITY) || (state == ST_STOP);
    start      = i_BitEn && (state == ST_IDLE) && !i_Rx;
    acc_en     = i_BitEn && ((state == ST_DATA) || (state == ST_PARITY));
    par_en     = i_BitEn && (state == ST_PARITY);
    frame_done = i_BitEn && (state == ST_STOP) && stop_last;
  end

  usrt_parity_acc u_par (
    .clk    (i_Pclk),
    .rst    (i_Rst),
    .clr    (start),
    .en     (acc_en),
    .par_en (par_en),
    .din    (i_Rx),
    .mode   (mode),
    .err    (perr)
  );

  always_ff @(posedge i_Pclk or posedge i_Rst) begin
    if (i_Rst) begin
      shreg       <= '0;
      bit_cnt     <= '0;
      stop_cnt    <= 1'b0;
      mode        <= PAR_NONE;
      ferr_acc    <= 1'b0;
      o_Data      <= '0;
      o_Valid     <= 1'b0;
      o_ParityErr <= 1'b0;
      o_FrameErr  <= 1'b0;
      o_ErrCnt    <= '0;
    end else begin
      o_Valid <= frame_done;
      if (start) begin
        mode     <= i_Parity;
        shreg    <= '0;
        bit_cnt  <= '0;
        stop_cnt <= 1'b0;
        ferr_acc <= 1'b0;
      end
      if (i_BitEn && state == ST_DATA) begin
        shreg   <= {i_Rx, shreg[DATA_W-1:1]};
        bit_cnt <= data_last ? '0 : bit_cnt + 1'b1;
      end
      if (i_BitEn && state == ST_STOP) begin
        stop_cnt <= stop_last ? 1'b0 : stop_cnt + 1'b1;
        if (!i_Rx) ferr_acc <= 1'b1;
      end
      if (frame_done) begin
        o_Data      <= shreg;
        o_ParityErr <= perr;
        o_FrameErr  <= ferr_acc | ~i_Rx;
      end
      if (i_ClrCnt)
        o_ErrCnt <= '0;
      else if (frame_done && frame_bad && !(&o_ErrCnt))
        o_ErrCnt <= o_ErrCnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_usrt_rx_framer.sv
// Directed frames with hand-computed results; a monitor pops the expected
// record whenever o_Valid is seen and compares all status fields.
module tb_usrt_rx_framer;
  import usrt_pkg::*;

  logic       clk = 1'b0;
  logic       rst, bit_en, rx, clr;
  logic [1:0] par;
  logic [7:0] data;
  logic       valid, perr, ferr, busy;
  logic [1:0] cnt;

  always #5 clk = ~clk;

  usrt_rx_framer #(.DATA_W(8), .STOP_BITS(1), .CNT_W(2)) dut (
    .i_Pclk      (clk),
    .i_Rst       (rst),
    .i_BitEn     (bit_en),
    .i_Rx        (rx),
    .i_Parity    (par),
    .i_ClrCnt    (clr),
    .o_Data      (data),
    .o_Valid     (valid),
    .o_ParityErr (perr),
    .o_FrameErr  (ferr),
    .o_Busy      (busy),
    .o_ErrCnt    (cnt)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    logic [1:0] c;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && valid === 1'b1) begin
      if (q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_valid: got valid with data %0h expected none", data);
      end else begin
        m_e = q.pop_front();
        chk("data",       32'(data), 32'(m_e.d));
        chk("parity_err", 32'(perr), 32'(m_e.pe));
        chk("frame_err",  32'(ferr), 32'(m_e.fe));
        chk("err_cnt",    32'(cnt),  32'(m_e.c));
      end
    end
  end

  // one strobe; called on a negedge, returns on a negedge
  task automatic sbit(input logic b, input int gap);
    rx = b;
    bit_en = 1'b1;
    @(negedge clk);
    bit_en = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic frame(input logic [7:0] d, input logic [1:0] m, input logic [1:0] m_mid,
                       input logic pb, input logic sb, input int gap, input logic clr_stop,
                       input logic [7:0] ed, input logic epe, input logic efe, input logic [1:0] ec);
    exp_t e;
    e.d = ed; e.pe = epe; e.fe = efe; e.c = ec;
    q.push_back(e);
    par = m;
    sbit(1'b0, gap);
    par = m_mid;
    for (int i = 0; i < 8; i++) sbit(d[i], gap);
    if (m != PAR_NONE) sbit(pb, gap);
    clr = clr_stop;
    sbit(sb, gap);
    clr = 1'b0;
    rx = 1'b1;
  endtask

  initial begin
    rst = 1'b1; bit_en = 1'b0; rx = 1'b1; clr = 1'b0; par = PAR_NONE;
    repeat (3) @(negedge clk);
    chk("rst_data",  32'(data),  32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_busy",  32'(busy),  32'h0);
    chk("rst_cnt",   32'(cnt),   32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // even/odd on 0xA5 (four ones), parity bit 0
    frame(8'hA5, PAR_EVEN, PAR_EVEN, 1'b0, 1'b1, 0, 1'b0, 8'hA5, 1'b0, 1'b0, 2'd0);
    chk("busy_after_frame", 32'(busy), 32'h0);
    frame(8'hA5, PAR_ODD, PAR_ODD, 1'b0, 1'b1, 0, 1'b0, 8'hA5, 1'b1, 1'b0, 2'd1);

    // no parity, bad stop, line held low: must not false-start
    frame(8'h3C, PAR_NONE, PAR_NONE, 1'b0, 1'b0, 0, 1'b0, 8'h3C, 1'b0, 1'b1, 2'd2);
    repeat (5) sbit(1'b0, 0);
    chk("no_false_start", 32'(busy), 32'h0);
    sbit(1'b1, 0);
    frame(8'h81, PAR_NONE, PAR_NONE, 1'b0, 1'b1, 0, 1'b0, 8'h81, 1'b0, 1'b0, 2'd2);

    // mark parity, back-to-back strobes then 3-cycle gaps
    frame(8'h00, PAR_MARK, PAR_MARK, 1'b0, 1'b1, 0, 1'b0, 8'h00, 1'b1, 1'b0, 2'd3);
    frame(8'h00, PAR_MARK, PAR_MARK, 1'b1, 1'b1, 0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd3);
    frame(8'h00, PAR_MARK, PAR_MARK, 1'b0, 1'b1, 3, 1'b0, 8'h00, 1'b1, 1'b0, 2'd3);
    frame(8'h00, PAR_MARK, PAR_MARK, 1'b1, 1'b1, 3, 1'b0, 8'h00, 1'b0, 1'b0, 2'd3);

    // parity mode switched to odd after start: frame stays even (0x01 + pb 1)
    frame(8'h01, PAR_EVEN, PAR_ODD, 1'b1, 1'b1, 0, 1'b0, 8'h01, 1'b0, 1'b0, 2'd3);

    // async reset after start + 4 data bits
    par = PAR_NONE;
    sbit(1'b0, 0);
    sbit(1'b0, 0); sbit(1'b1, 0); sbit(1'b0, 0); sbit(1'b1, 0);
    chk("busy_mid_frame", 32'(busy), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("arst_data",  32'(data),  32'h0);
    chk("arst_valid", 32'(valid), 32'h0);
    chk("arst_perr",  32'(perr),  32'h0);
    chk("arst_ferr",  32'(ferr),  32'h0);
    chk("arst_busy",  32'(busy),  32'h0);
    chk("arst_cnt",   32'(cnt),   32'h0);
    rx = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    frame(8'h5A, PAR_NONE, PAR_NONE, 1'b0, 1'b1, 0, 1'b0, 8'h5A, 1'b0, 1'b0, 2'd0);

    // counter saturation at 3
    frame(8'hFF, PAR_NONE, PAR_NONE, 1'b0, 1'b0, 0, 1'b0, 8'hFF, 1'b0, 1'b1, 2'd1);
    sbit(1'b1, 0);
    frame(8'hFF, PAR_NONE, PAR_NONE, 1'b0, 1'b0, 0, 1'b0, 8'hFF, 1'b0, 1'b1, 2'd2);
    sbit(1'b1, 0);
    frame(8'hFF, PAR_NONE, PAR_NONE, 1'b0, 1'b0, 0, 1'b0, 8'hFF, 1'b0, 1'b1, 2'd3);
    sbit(1'b1, 0);
    frame(8'hFF, PAR_NONE, PAR_NONE, 1'b0, 1'b0, 0, 1'b0, 8'hFF, 1'b0, 1'b1, 2'd3);
    sbit(1'b1, 0);

    // clear on the same edge as an errored frame wins
    frame(8'h0F, PAR_EVEN, PAR_EVEN, 1'b1, 1'b1, 0, 1'b1, 8'h0F, 1'b1, 1'b0, 2'd0);
    frame(8'h0F, PAR_ODD, PAR_ODD, 1'b1, 1'b1, 0, 1'b0, 8'h0F, 1'b0, 1'b0, 2'd0);

    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      n_chk++;
      $display("FAIL drain: %0d frames outstanding, expected 0", q.size());
    end
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
